// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rtc_pkg
// Brief   : Shared edit-state encoding, field limits and leap-year helper
// Revision: 1.0
// ============================================================================
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_HOUR  = 3'd1,
    ST_SET_MIN   = 3'd2,
    ST_SET_DAY   = 3'd3,
    ST_SET_MONTH = 3'd4,
    ST_SET_YEAR  = 3'd5
  } state_t;

  localparam logic [5:0]  SEC_MAX   = 6'd59;
  localparam logic [5:0]  MIN_MAX   = 6'd59;
  localparam logic [4:0]  HOUR_MAX  = 5'd23;
  localparam logic [3:0]  MONTH_MAX = 4'd12;
  localparam logic [11:0] YEAR_MAX  = 12'd4095;

  // Gregorian rule; year 0 falls out as a leap year.
  function automatic logic is_leap(input logic [11:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_calendar_days_in_month.sv
`default_nettype none
// ============================================================================
// Module  : days_in_month
// Brief   : Combinational month length for a given month/year
// Revision: 1.0
// ============================================================================
module days_in_month (
  input  logic [3:0]  month,
  input  logic [11:0] year,
  output logic [4:0]  dim
);
  import rtc_pkg::*;

  always_comb begin
    dim = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module  : rtc_calendar
// Brief   : 1 Hz time/date counter with two-button field editing
// Revision: 1.0
// ============================================================================
module rtc_calendar #(
  parameter int CLK_HZ      = 50000000,
  parameter int RESET_YEAR  = 2024,
  parameter int RESET_MONTH = 1,
  parameter int RESET_DAY   = 1,
  parameter int RESET_HOUR  = 0,
  parameter int RESET_MIN   = 0
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [11:0] year,
  output logic [2:0]  edit_field,
  output logic        tick_1hz
);
  import rtc_pkg::*;

  localparam int             PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    sec_nxt, min_nxt;
  logic [4:0]    hour_nxt, day_nxt;
  logic [3:0]    month_nxt, month_inc, edit_month;
  logic [11:0]   year_nxt, year_inc, edit_year;
  logic [4:0]    dim_cur, dim_edit;
  logic          tick;

  assign month_inc = (month == MONTH_MAX) ? 4'd1 : month + 4'd1;
  assign year_inc  = (year == YEAR_MAX) ? 12'd0 : year + 12'd1;

  // Second lookup sees the month/year an increment would produce, so the
  // day clamp lands on the same edge as the increment.
  assign edit_month = (state == ST_SET_MONTH) ? month_inc : month;
  assign edit_year  = (state == ST_SET_YEAR)  ? year_inc  : year;

  days_in_month u_dim_cur  (.month(month),      .year(year),      .dim(dim_cur));
  days_in_month u_dim_edit (.month(edit_month), .year(edit_year), .dim(dim_edit));

  assign tick       = (presc == PRESC_MAX) && (state == ST_RUN);
  assign tick_1hz   = tick;
  assign edit_field = state;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    sec_nxt   = sec;
    min_nxt   = min;
    hour_nxt  = hour;
    day_nxt   = day;
    month_nxt = month;
    year_nxt  = year;
    case (state)
      ST_RUN: begin
        presc_nxt = tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (sec != SEC_MAX) sec_nxt = sec + 6'd1;
          else begin
            sec_nxt = 6'd0;
            if (min != MIN_MAX) min_nxt = min + 6'd1;
            else begin
              min_nxt = 6'd0;
              if (hour != HOUR_MAX) hour_nxt = hour + 5'd1;
              else begin
                hour_nxt = 5'd0;
                if (day != dim_cur) day_nxt = day + 5'd1;
                else begin
                  day_nxt   = 5'd1;
                  month_nxt = month_inc;
                  if (month == MONTH_MAX) year_nxt = year_inc;
                end
              end
            end
          end
        end
        if (btn_mode) begin
          state_nxt = ST_SET_HOUR;
          presc_nxt = '0;
        end
      end
      ST_SET_HOUR: begin
        presc_nxt = '0;
        if (btn_mode)     state_nxt = ST_SET_MIN;
        else if (btn_inc) hour_nxt = (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
      end
      ST_SET_MIN: begin
        presc_nxt = '0;
        if (btn_mode)     state_nxt = ST_SET_DAY;
        else if (btn_inc) min_nxt = (min == MIN_MAX) ? 6'd0 : min + 6'd1;
      end
      ST_SET_DAY: begin
        presc_nxt = '0;
        if (btn_mode)     state_nxt = ST_SET_MONTH;
        else if (btn_inc) day_nxt = (day >= dim_cur) ? 5'd1 : day + 5'd1;
      end
      ST_SET_MONTH: begin
        presc_nxt = '0;
        if (btn_mode) state_nxt = ST_SET_YEAR;
        else if (btn_inc) begin
          month_nxt = month_inc;
          if (day > dim_edit) day_nxt = dim_edit;
        end
      end
      ST_SET_YEAR: begin
        presc_nxt = '0;
        if (btn_mode) begin
          state_nxt = ST_RUN;
          sec_nxt   = 6'd0;
        end else if (btn_inc) begin
          year_nxt = year_inc;
          if (day > dim_edit) day_nxt = dim_edit;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= ST_RUN;
      presc <= '0;
      sec   <= 6'd0;
      min   <= 6'(RESET_MIN);
      hour  <= 5'(RESET_HOUR);
      day   <= 5'(RESET_DAY);
      month <= 4'(RESET_MONTH);
      year  <= 12'(RESET_YEAR);
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      sec   <= sec_nxt;
      min   <= min_nxt;
      hour  <= hour_nxt;
      day   <= day_nxt;
      month <= month_nxt;
      year  <= year_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module  : tb_rtc_calendar
// Brief   : Directed scoreboard bench for rtc_calendar (CLK_HZ = 4)
// Revision: 1.0
// ============================================================================
module tb_rtc_calendar;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [5:0]  sec, min;
  logic [4:0]  hour, day;
  logic [3:0]  month;
  logic [11:0] year;
  logic [2:0]  edit_field;
  logic        tick_1hz;

  rtc_calendar #(
    .CLK_HZ(4), .RESET_YEAR(2023), .RESET_MONTH(12), .RESET_DAY(31),
    .RESET_HOUR(23), .RESET_MIN(59)
  ) dut (
    .clk(clk), .rst_p(rst_p), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
    .edit_field(edit_field), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    due;
    int    kind;   // 0 = full snapshot, 1 = tick only
    string name;
    int    y, mo, d, h, mi, s, ef, tk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due on this cycle and compares it
  // against the registered outputs, half a clock after the edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.due != cyc)
        $display("FAIL %s: sample missed, due cycle %0d, now %0d", mon_e.name, mon_e.due, cyc);
      else if (mon_e.kind == 1) begin
        if (int'(tick_1hz) == mon_e.tk) passed++;
        else $display("FAIL %s: tick_1hz got %0d, expected %0d", mon_e.name, tick_1hz, mon_e.tk);
      end else begin
        if (int'(year) == mon_e.y && int'(month) == mon_e.mo && int'(day) == mon_e.d &&
            int'(hour) == mon_e.h && int'(min) == mon_e.mi && int'(sec) == mon_e.s &&
            int'(edit_field) == mon_e.ef && int'(tick_1hz) == mon_e.tk)
          passed++;
        else
          $display("FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d field=%0d tick=%0d, expected %0d-%0d-%0d %0d:%0d:%0d field=%0d tick=%0d",
                   mon_e.name, year, month, day, hour, min, sec, edit_field, tick_1hz,
                   mon_e.y, mon_e.mo, mon_e.d, mon_e.h, mon_e.mi, mon_e.s, mon_e.ef, mon_e.tk);
      end
    end
  end

  function automatic void exp_full(input string nm, input int y, input int mo, input int d,
                                   input int h, input int mi, input int s, input int ef, input int tk);
    exp_t e;
    e.due = cyc; e.kind = 0; e.name = nm;
    e.y = y; e.mo = mo; e.d = d; e.h = h; e.mi = mi; e.s = s; e.ef = ef; e.tk = tk;
    sb.push_back(e);
  endfunction

  function automatic void exp_tick(input string nm, input int tk);
    exp_t e;
    e.due = cyc; e.kind = 1; e.name = nm;
    e.y = 0; e.mo = 0; e.d = 0; e.h = 0; e.mi = 0; e.s = 0; e.ef = 0; e.tk = tk;
    sb.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m; btn_inc = i;
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic incs(input int n);
    if (n > 0) begin
      btn_inc = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      btn_inc = 1'b0;
    end
  endtask

  // From SET_YEAR: exit, verify first tick timing, run 60 s to the rollover.
  task automatic exit_and_roll(input string nm, input int y, input int mo, input int d,
                               input int y2, input int mo2, input int d2);
    press(1'b1, 1'b0);
    exp_full({nm, "_exit"}, y, mo, d, 23, 59, 0, 0, 0);
    step(3);
    exp_full({nm, "_first_tick"}, y, mo, d, 23, 59, 0, 0, 1);
    step(236);
    exp_full({nm, "_pre"}, y, mo, d, 23, 59, 59, 0, 1);
    step(1);
    exp_full({nm, "_post"}, y2, mo2, d2, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_p = 1'b0;
    exp_full("reset", 2023, 12, 31, 23, 59, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      exp_tick("tick_period", (i % 4 == 3) ? 1 : 0);
    end
    step(231);
    exp_full("pre_newyear", 2023, 12, 31, 23, 59, 59, 0, 1);
    step(1);
    exp_full("newyear", 2024, 1, 1, 0, 0, 0, 0, 0);
    step(20);
    exp_full("run_5s", 2024, 1, 1, 0, 0, 5, 0, 0);
    press(1'b0, 1'b1);
    exp_full("inc_in_run", 2024, 1, 1, 0, 0, 5, 0, 0);

    // Edit walk towards 2023-02-28 23:59, sec frozen at 5 throughout.
    press(1'b1, 1'b0);
    exp_full("enter_set", 2024, 1, 1, 0, 0, 5, 1, 0);
    step(8);
    exp_full("frozen", 2024, 1, 1, 0, 0, 5, 1, 0);
    incs(23);
    exp_full("hour23", 2024, 1, 1, 23, 0, 5, 1, 0);
    incs(1);
    exp_full("hour_wrap", 2024, 1, 1, 0, 0, 5, 1, 0);
    incs(23);
    press(1'b1, 1'b0);
    exp_full("set_min", 2024, 1, 1, 23, 0, 5, 2, 0);
    incs(59);
    press(1'b1, 1'b1);
    exp_full("mode_wins", 2024, 1, 1, 23, 59, 5, 3, 0);
    incs(27);
    press(1'b1, 1'b0);
    incs(1);
    exp_full("feb", 2024, 2, 28, 23, 59, 5, 4, 0);
    press(1'b1, 1'b0);
    incs(4095);
    exp_full("year_wrap", 2023, 2, 28, 23, 59, 5, 5, 0);
    exit_and_roll("y2023", 2023, 2, 28, 2023, 3, 1);

    // 2024-02-28 -> 02-29
    press(1'b1, 1'b0); incs(23);
    press(1'b1, 1'b0); incs(59);
    press(1'b1, 1'b0); incs(27);
    press(1'b1, 1'b0); incs(11);
    press(1'b1, 1'b0); incs(1);
    exp_full("set_2024", 2024, 2, 28, 23, 59, 0, 5, 0);
    exit_and_roll("y2024", 2024, 2, 28, 2024, 2, 29);

    // Year increment clamps Feb 29, then on to 2100 (not leap)
    press(1'b1, 1'b0); incs(23);
    press(1'b1, 1'b0); incs(59);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0); incs(1);
    exp_full("leap_clamp", 2025, 2, 28, 23, 59, 0, 5, 0);
    incs(75);
    exit_and_roll("y2100", 2100, 2, 28, 2100, 3, 1);

    // 2000 is a leap year
    press(1'b1, 1'b0); incs(23);
    press(1'b1, 1'b0); incs(59);
    press(1'b1, 1'b0); incs(27);
    press(1'b1, 1'b0); incs(11);
    press(1'b1, 1'b0); incs(3996);
    exit_and_roll("y2000", 2000, 2, 28, 2000, 2, 29);

    // Day wrap in SET_DAY and month-increment clamp 31 Mar -> 30 Apr
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0); incs(1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    incs(2);
    exp_full("day31", 2000, 3, 31, 0, 0, 0, 3, 0);
    incs(1);
    exp_full("day_wrap", 2000, 3, 1, 0, 0, 0, 3, 0);
    incs(30);
    press(1'b1, 1'b0); incs(1);
    exp_full("month_clamp", 2000, 4, 30, 0, 0, 0, 4, 0);

    // Reset in SET_MONTH discards the edit and restarts the prescaler
    rst_p = 1'b1; btn_inc = 1'b1;
    @(posedge clk); #1;
    rst_p = 1'b0; btn_inc = 1'b0;
    exp_full("reset_mid_edit", 2023, 12, 31, 23, 59, 0, 0, 0);
    step(3);
    exp_full("tick_after_reset", 2023, 12, 31, 23, 59, 0, 0, 1);
    step(1);
    exp_full("sec_after_reset", 2023, 12, 31, 23, 59, 1, 0, 0);

    step(2);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      $display("FAIL %s: never sampled, got none, expected a sample", mon_e.name);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_calendar.md
Name: rtc_calendar

Overview:
- Time-of-day and calendar counter that produces the binary sec/min/hour/day/month/year values consumed by the 7-segment display block.
- Advances once per second, derived from the system clock by a prescaler.
- Full Gregorian month-length and leap-year handling.
- Two-button set mode (mode, increment) lets the user edit hour, minute, day, month and year before the clock resumes.

Parameters:
- CLK_HZ, 50000000, system clock cycles per second (prescaler terminal count + 1); must be >= 2.
- RESET_YEAR, 2024, year loaded on reset (0..4095).
- RESET_MONTH, 1, month loaded on reset (1..12).
- RESET_DAY, 1, day loaded on reset (1..days in RESET_MONTH).
- RESET_HOUR, 0, hour loaded on reset (0..23).
- RESET_MIN, 0, minute loaded on reset (0..59).

Ports:
- clk  in  1  system clock.
- rst_p  in  1  synchronous, active-high reset.
- btn_mode  in  1  one-cycle pulse, debounced upstream; advances edit state.
- btn_inc  in  1  one-cycle pulse, debounced upstream; increments the field being edited.
- sec  out  6  seconds 0..59.
- min  out  6  minutes 0..59.
- hour  out  5  hours 0..23.
- day  out  5  day of month 1..31.
- month  out  4  month 1..12.
- year  out  12  year 0..4095.
- edit_field  out  3  0=RUN, 1=HOUR, 2=MIN, 3=DAY, 4=MONTH, 5=YEAR.
- tick_1hz  out  1  one-cycle pulse per advanced second.

Behaviour:
- Interface: one clock, clk. Reset rst_p is synchronous and active-high.
- Reset (a clk edge with rst_p=1): sec=0, min=RESET_MIN, hour=RESET_HOUR, day=RESET_DAY, month=RESET_MONTH, year=RESET_YEAR, prescaler=0, state=RUN, edit_field=0.
  - Reset overrides all other inputs.
  - Reset in mid-edit discards the edit.
- All value outputs and edit_field are registered.
- Prescaler:
  - In RUN, counts 0..CLK_HZ-1, then wraps to 0.
  - tick_1hz = (prescaler == CLK_HZ-1) && state==RUN; it is combinational from registers.
  - The time fields advance on the clk edge that ends the tick cycle.
  - Outside RUN the prescaler holds at 0 and tick_1hz=0.
- Cascade on tick, all in one edge:
  - sec 59 -> 0 carries to min.
  - min 59 -> 0 carries to hour.
  - hour 23 -> 0 carries to day.
  - day == dim(month, year) -> 1 carries to month.
  - month 12 -> 1 carries to year.
  - year 4095 -> 0.
- dim (days in month):
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - 28 for month 2, or 29 when leap.
  - Leap = (year mod 4 == 0) && (year mod 100 != 0 || year mod 400 == 0); year 0 counts as leap.
- FSM: RUN -> SET_HOUR -> SET_MIN -> SET_DAY -> SET_MONTH -> SET_YEAR -> RUN; each transition happens on btn_mode.
- In SET_* states:
  - btn_inc increments only the edited field, with wrap: hour 23->0, min 59->0, day dim->1, month 12->1, year 4095->0.
  - No carry into other fields.
- Day clamp: after a month or year increment in set mode, if day > new dim, day becomes new dim in the same edge (e.g. 31 Mar -> inc month -> 30 Apr).
- Leaving SET_YEAR for RUN clears sec and prescaler to 0, so the first tick comes CLK_HZ cycles later.
- btn_mode and btn_inc in the same cycle: mode wins, inc is ignored.
- btn_inc in RUN is ignored.
- Entering SET_HOUR on a tick cycle: the tick's update is applied on that edge, then counting freezes.

Decomposition:
- Package rtc_pkg holds:
  - the state enum / edit_field encodings (RUN..SET_YEAR);
  - field maxima: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12, YEAR_MAX=4095.
- Sub-module days_in_month: purely combinational, inputs month[3:0] and year[11:0], output dim[4:0] including the leap rule. It is instantiated once for the running date; set-mode clamp logic uses a second instance on the next month/year.

Test Plan:
- CLK_HZ=4, reset to 2023-12-31 23:59, advance 59 ticks -> at 60th tick outputs 2024-01-01 00:00:00; tick_1hz pulses every 4 cycles exactly.
- Date 2023-02-28 23:59:59 + 1 tick -> 2023-03-01; date 2024-02-28 23:59:59 + 1 tick -> 2024-02-29; 2100-02-28 -> 03-01; 2000-02-28 -> 02-29.
- Set mode walk: 5 btn_mode pulses -> edit_field 1,2,3,4,5,0; no ticks and sec frozen while editing; sec=0 on return to RUN; first tick_1hz 4 cycles after exit.
- Edit wrap and clamp: SET_HOUR from 23 + inc -> 0, min unchanged; day 31 month 3 in SET_MONTH + inc -> month 4 day 30; 2024-02-29 in SET_YEAR + inc -> 2025-02-28.
- Simultaneous btn_mode+btn_inc in SET_MIN -> state SET_DAY, min unchanged; btn_inc in RUN -> no change.
- Assert rst_p while in SET_MONTH with edited values -> next cycle all reset values, edit_field=0, prescaler restarts at 0.
